// File: rtl/lpc_io_host.sv
// lpc_io_host
// LPC host-side initiator. Each accepted request becomes one LPC I/O cycle:
// START, CYCTYPE/DIR, four address nibbles (MSN first), two write-data
// nibbles (LSN first, writes only), host turn-around, SYNC, two read-data
// nibbles (reads only) and peripheral turn-around. If no valid SYNC arrives,
// or long waits run too long, the host drives the ABORT pattern. The result
// is returned as a one-clock response pulse.
//
// Ports
//   clk, reset            LPC clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 = I/O write, 0 = I/O read
//   req_addr, req_wdata   16-bit I/O address, write byte
//   rsp_valid             one-clock completion pulse
//   rsp_rdata             read byte (0xFF on abort, 0x00 for writes)
//   rsp_error             error SYNC seen or abort taken
//   rsp_timeout           abort taken
//   lpc_lframe_n          LFRAME#
//   lpc_lad_out/_oe       LAD drive value and enable (tristate built above)
//   lpc_lad_in            sampled LAD
module lpc_io_host #(
  parameter int NOSYNC_LIMIT   = 3,
  parameter int LONGWAIT_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        lpc_lframe_n,
  output logic [3:0]  lpc_lad_out,
  output logic        lpc_lad_oe,
  input  logic [3:0]  lpc_lad_in
);

  localparam logic [9:0] NS_LIM = 10'(NOSYNC_LIMIT);
  localparam logic [9:0] LW_LIM = 10'(LONGWAIT_LIMIT);

  typedef enum logic [4:0] {
    IDLE, START, CYCTYPE, ADDR0, ADDR1, ADDR2, ADDR3, WDATA0, WDATA1,
    HTAR0, HTAR1, SYNC, RDATA0, RDATA1, PTAR0, PTAR1, DONE, ABORT
  } state_t;

  state_t      state;
  logic        is_write;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        err_seen;
  logic [9:0]  nosync_cnt;
  logic [9:0]  longwait_cnt;
  logic [1:0]  abort_cnt;
  logic [9:0]  nosync_inc;
  logic [9:0]  longwait_inc;

  // Saturating increments of the SYNC watchdog counters.
  always_comb begin
    nosync_inc   = (nosync_cnt == 10'h3FF) ? nosync_cnt : nosync_cnt + 10'd1;
    longwait_inc = (longwait_cnt == 10'h3FF) ? longwait_cnt : longwait_cnt + 10'd1;
  end

  // Cycle sequencer. Every transition also loads the bus drive for the state
  // being entered, so LFRAME#/LAD/OE come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lpc_lframe_n <= 1'b1;
      lpc_lad_out  <= 4'hF;
      lpc_lad_oe   <= 1'b0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
      rsp_error    <= 1'b0;
      rsp_timeout  <= 1'b0;
      is_write     <= 1'b0;
      addr         <= 16'h0000;
      wdata        <= 8'h00;
      rdata        <= 8'h00;
      err_seen     <= 1'b0;
      nosync_cnt   <= 10'd0;
      longwait_cnt <= 10'd0;
      abort_cnt    <= 2'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state        <= START;
            req_ready    <= 1'b0;
            is_write     <= req_write;
            addr         <= req_addr;
            wdata        <= req_wdata;
            err_seen     <= 1'b0;
            nosync_cnt   <= 10'd0;
            longwait_cnt <= 10'd0;
            lpc_lframe_n <= 1'b0;
            lpc_lad_out  <= 4'h0;
            lpc_lad_oe   <= 1'b1;
          end else begin
            req_ready    <= 1'b1;
            lpc_lframe_n <= 1'b1;
            lpc_lad_out  <= 4'hF;
            lpc_lad_oe   <= 1'b0;
          end
        end
        START: begin
          state        <= CYCTYPE;
          lpc_lframe_n <= 1'b1;
          lpc_lad_out  <= is_write ? 4'h2 : 4'h0;
        end
        CYCTYPE: begin
          state       <= ADDR0;
          lpc_lad_out <= addr[15:12];
        end
        ADDR0: begin
          state       <= ADDR1;
          lpc_lad_out <= addr[11:8];
        end
        ADDR1: begin
          state       <= ADDR2;
          lpc_lad_out <= addr[7:4];
        end
        ADDR2: begin
          state       <= ADDR3;
          lpc_lad_out <= addr[3:0];
        end
        ADDR3: begin
          if (is_write) begin
            state       <= WDATA0;
            lpc_lad_out <= wdata[3:0];
          end else begin
            state       <= HTAR0;
            lpc_lad_out <= 4'hF;
          end
        end
        WDATA0: begin
          state       <= WDATA1;
          lpc_lad_out <= wdata[7:4];
        end
        WDATA1: begin
          state       <= HTAR0;
          lpc_lad_out <= 4'hF;
        end
        HTAR0: begin
          state      <= HTAR1;
          lpc_lad_oe <= 1'b0;
        end
        HTAR1: begin
          state <= SYNC;
        end
        // Ready and error codes end SYNC; waits hold it. Anything that is not
        // a SYNC code counts toward the no-device abort.
        SYNC: begin
          case (lpc_lad_in)
            4'b0000, 4'b1010: begin
              if (lpc_lad_in == 4'b1010) err_seen <= 1'b1;
              nosync_cnt <= 10'd0;
              state      <= is_write ? PTAR0 : RDATA0;
            end
            4'b0101: begin
              nosync_cnt <= 10'd0;
            end
            4'b0110: begin
              nosync_cnt   <= 10'd0;
              longwait_cnt <= longwait_inc;
              if (longwait_inc >= LW_LIM) begin
                state        <= ABORT;
                abort_cnt    <= 2'd0;
                lpc_lframe_n <= 1'b0;
                lpc_lad_out  <= 4'hF;
                lpc_lad_oe   <= 1'b1;
              end
            end
            default: begin
              nosync_cnt <= nosync_inc;
              if (nosync_inc >= NS_LIM) begin
                state        <= ABORT;
                abort_cnt    <= 2'd0;
                lpc_lframe_n <= 1'b0;
                lpc_lad_out  <= 4'hF;
                lpc_lad_oe   <= 1'b1;
              end
            end
          endcase
        end
        RDATA0: begin
          state      <= RDATA1;
          rdata[3:0] <= lpc_lad_in;
        end
        RDATA1: begin
          state      <= PTAR0;
          rdata[7:4] <= lpc_lad_in;
        end
        PTAR0: begin
          state <= PTAR1;
        end
        PTAR1: begin
          state       <= DONE;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= is_write ? 8'h00 : rdata;
          rsp_error   <= err_seen;
          rsp_timeout <= 1'b0;
        end
        // Abort pattern is held for exactly four clocks.
        ABORT: begin
          if (abort_cnt == 2'd3) begin
            state        <= DONE;
            lpc_lframe_n <= 1'b1;
            lpc_lad_oe   <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= 8'hFF;
            rsp_error    <= 1'b1;
            rsp_timeout  <= 1'b1;
          end else begin
            abort_cnt <= abort_cnt + 2'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
